// File: rtl/cpu_div_sequencer.sv
// Multi-cycle radix-2 restoring divide/remainder sequencer for the execute stage.
// Optional macro DIV_EARLY_OUT_EN: skip the iteration loop when |divisor| > |dividend|.
module cpu_div_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             p3_div_start,
  input  logic [1:0]       p3_div_op,
  input  logic [WIDTH-1:0] p3_a,
  input  logic [WIDTH-1:0] p3_b,
  input  logic [4:0]       p3_reg_d,
  input  logic             p3_flush,
  input  logic             div_ack,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] div_result,
  output logic [4:0]       div_reg_d
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [4:0]       rd_q, rd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       out_rd_q, out_rd_d;

  logic             take;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign take = p3_div_start & ~p3_flush;

  // op[0] selects signed; the most negative value maps to itself as an unsigned magnitude
  assign a_mag = (op_q[0] && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag = (op_q[0] && b_q[WIDTH-1]) ? -b_q : b_q;

  // Stored remainder is always below the divisor, so WIDTH bits suffice between steps
  assign rem_sh = {rem_q, quot_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  assign q_fix = qneg_q ? -quot_q : quot_q;
  assign r_fix = rneg_q ? -rem_q  : rem_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rd_d     = rd_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    out_rd_d = out_rd_q;
    div_busy = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (take) begin
          op_d    = p3_div_op;
          a_d     = p3_a;
          b_d     = p3_b;
          rd_d    = p3_reg_d;
          state_d = S_PREP;
        end
      end

      S_PREP: begin
        div_busy = 1'b1;
        qneg_d   = op_q[0] & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_d   = op_q[0] & a_q[WIDTH-1];
        dvs_d    = b_mag;
        quot_d   = a_mag;
        rem_d    = '0;
        cnt_d    = '0;
        if (b_q == '0) begin
          // Divide by zero returns raw values: no sign correction applied
          quot_d  = '1;
          rem_d   = a_q;
          qneg_d  = 1'b0;
          rneg_d  = 1'b0;
          state_d = S_FIX;
        end
`ifdef DIV_EARLY_OUT_EN
        else if (b_mag > a_mag) begin
          quot_d  = '0;
          rem_d   = a_mag;
          state_d = S_FIX;
        end
`endif
        else begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        div_busy = 1'b1;
        if (!trial[WIDTH]) begin
          rem_d  = trial[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d  = rem_sh[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        div_busy = 1'b1;
        result_d = op_q[1] ? r_fix : q_fix;
        out_rd_d = rd_q;
        state_d  = S_DONE;
      end

      S_DONE: begin
        div_busy = ~div_ack;
        if (div_ack) begin
          if (take) begin
            op_d    = p3_div_op;
            a_d     = p3_a;
            b_d     = p3_b;
            rd_d    = p3_reg_d;
            state_d = S_PREP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything, including a result that would be written this cycle
    if (p3_flush && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      result_d = result_q;
      out_rd_d = out_rd_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      out_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      out_rd_q <= out_rd_d;
    end
  end

  assign div_done   = (state_q == S_DONE);
  assign div_result = result_q;
  assign div_reg_d  = out_rd_q;

endmodule

// File: doc/cpu_div_sequencer.md
Name: cpu_div_sequencer

Overview:
Multi-cycle integer divide/remainder controller for the execute stage. It accepts a divide op from p3, runs a radix-2 restoring shift-subtract loop, and holds the pipeline with div_busy until the result is consumed. It also applies sign correction and the divide-by-zero convention, then returns the result with its destination register for p4 writeback.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count equals WIDTH
CNT_W, 6, width of iteration counter; must satisfy 2^CNT_W > WIDTH

Ports:
clock        input   1      rising-edge clock
reset        input   1      asynchronous, active-low; 0 = reset
p3_div_start input   1      request a divide this cycle
p3_div_op    input   2      00 divu, 01 div, 10 remu, 11 rem
p3_a         input   WIDTH  dividend
p3_b         input   WIDTH  divisor
p3_reg_d     input   5      destination register
p3_flush     input   1      abort (jump/exception); kills in-flight op
div_ack      input   1      writeback consumed the result this cycle
div_busy     output  1      stall request to pipeline
div_done     output  1      result valid
div_result   output  WIDTH  quotient or remainder
div_reg_d    output  5      destination register of result

Behaviour:
- Reset (reset=0, async): state IDLE; div_busy=0, div_done=0, div_result=0, div_reg_d=0; counter and internal registers cleared.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE: on p3_div_start=1 and p3_flush=0, latch op, a, b, reg_d → PREP. div_busy=0 in IDLE.
- PREP, 1 cycle:
  - signed ops: magnitudes |a|, |b|; record quotient sign = a[msb]^b[msb] and remainder sign = a[msb].
  - unsigned ops: no sign change.
  - If b==0 → FIX with quotient = all ones and remainder = a (raw, no sign fix); else → RUN with counter=0.
- RUN: one quotient bit per cycle, MSB first.
  - Partial remainder is WIDTH+1 bits. Shift {rem,quot} left by 1; trial subtract divisor; if non-negative keep it and set quot[0]=1.
  - After WIDTH cycles (counter==WIDTH-1) → FIX.
- FIX, 1 cycle:
  - Negate quotient if its sign flag is set; negate remainder if its sign flag is set.
  - Select quotient for op[1]=0, remainder for op[1]=1 → DONE.
- DONE: div_done=1, div_result and div_reg_d stable.
  - On div_ack=1 → IDLE.
  - If p3_div_start=1 in the same cycle as div_ack, the new op is latched and the state goes straight to PREP (back-to-back, no idle cycle).
- div_busy = 1 in PREP, RUN, FIX. div_busy = 1 in DONE unless div_ack=1 that cycle.
- Latency: start at cycle N → div_done high at cycle N+WIDTH+3 (N+35 at default). Divide by zero gives N+3.
- Overflow: div 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. No trap.
- p3_flush=1 in any state except IDLE → IDLE next cycle. div_done drops, no result is produced, and a start in that same cycle is ignored.
- p3_div_start while not IDLE/DONE-with-ack: ignored. The pipeline guarantees this via div_busy.
- Width rules: all arithmetic is modulo 2^WIDTH. Negation is two's complement, and |0x80000000| = 0x80000000 treated as unsigned.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: in PREP, if divisor magnitude > dividend magnitude (unsigned compare), skip RUN. The raw result is quotient=0, remainder=dividend magnitude, and the state goes → FIX. Latency becomes 3 cycles.
- Undefined: every nonzero-divisor op takes the full WIDTH+3 cycles.
- Results are identical in both builds; only latency differs.

Test Plan:
- divu a=100, b=7, reg_d=5 → div_done at start+35, div_result=14, div_reg_d=5; div_busy high from start+1 until ack.
- rem a=-100 (0xFFFFFF9C), b=7 → div_result=0xFFFFFFFE (-2). div a=-100, b=7 → 0xFFFFFFF2 (-14).
- div a=0x80000000, b=0xFFFFFFFF → div_result=0x80000000. remu a=123, b=0 → 123 at start+3. divu a=123, b=0 → 0xFFFFFFFF.
- Assert p3_flush at start+10 → IDLE at start+11, div_done never asserts, div_busy=0. A new start at start+12 completes normally.
- Hold div_ack=0 for 5 cycles in DONE → div_result stable and div_busy=1. Ack together with a new start (divu 9/3) → result 3 at ack+35, no idle cycle.
- Pull reset low mid-RUN, asynchronously between edges → all outputs 0 immediately. With DIV_EARLY_OUT_EN, divu 5/9 → done at start+3 with result 0.
